// File: rtl/pipelined_addsub.sv
// Pipelined N-bit adder/subtractor: one W=N/STAGES chunk per stage, carry registered between stages.
// Optional signed-overflow output is compiled in with `define ADDER_OVF_EN.
module pipelined_addsub #(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  input  logic         carryin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] f,
  output logic         carryout
`ifdef ADDER_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int W = N / STAGES;

  logic         stall;
  logic [N-1:0] b_eff;
  logic         c0;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign b_eff    = b ^ {N{sub}};
  assign c0       = carryin ^ sub;

  function automatic logic [W:0] add_chunk(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // Stage k consumes the lowest remaining operand chunk; unused upper chunks ride along
  // shifted down, and finished result chunks accumulate so a beat's chunks leave together.
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int DONE = (k + 1) * W;
    localparam int REM  = N - DONE;

    logic [W-1:0]    a_ck, b_ck;
    logic            c_in, v_in, ld;
    logic [W:0]      sum;
    logic [DONE-1:0] f_d, f_q;
    logic            c_d, c_q;
    logic            vld_q;

    if (k == 0) begin : g_in
      assign a_ck = a[W-1:0];
      assign b_ck = b_eff[W-1:0];
      assign c_in = c0;
      assign v_in = in_valid;
      assign f_d  = sum[W-1:0];
    end else begin : g_in
      assign a_ck = g_stg[k-1].g_ops.a_q[W-1:0];
      assign b_ck = g_stg[k-1].g_ops.b_q[W-1:0];
      assign c_in = g_stg[k-1].c_q;
      assign v_in = g_stg[k-1].vld_q;
      assign f_d  = {sum[W-1:0], g_stg[k-1].f_q};
    end

    assign sum = add_chunk(a_ck, b_ck, c_in);
    assign c_d = sum[W];
    assign ld  = !stall && v_in;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      vld_q <= 1'b0;
      else if (!stall) vld_q <= v_in;
    end

    if (REM > 0) begin : g_ops
      logic [REM-1:0] a_d, b_d, a_q, b_q;
      if (k == 0) begin : g_src
        assign a_d = a[N-1:W];
        assign b_d = b_eff[N-1:W];
      end else begin : g_src
        assign a_d = g_stg[k-1].g_ops.a_q[REM+W-1:W];
        assign b_d = g_stg[k-1].g_ops.b_q[REM+W-1:W];
      end
      always_ff @(posedge clk) begin
        if (ld) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    // Output stage is reset so f/carryout read 0 until the first beat arrives.
    if (k == STAGES - 1) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          f_q <= '0;
          c_q <= 1'b0;
        end else if (ld) begin
          f_q <= f_d;
          c_q <= c_d;
        end
      end
    end else begin : g_reg
      always_ff @(posedge clk) begin
        if (ld) begin
          f_q <= f_d;
          c_q <= c_d;
        end
      end
    end
  end

  assign out_valid = g_stg[STAGES-1].vld_q;
  assign f         = g_stg[STAGES-1].f_q;
  assign carryout  = g_stg[STAGES-1].c_q;

`ifdef ADDER_OVF_EN
  // The top chunk holds the sign bits, so overflow is resolved in the last stage.
  logic ovf_d, ovf_q;
  assign ovf_d = (g_stg[STAGES-1].a_ck[W-1] == g_stg[STAGES-1].b_ck[W-1]) &&
                 (g_stg[STAGES-1].sum[W-1] != g_stg[STAGES-1].a_ck[W-1]);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  ovf_q <= 1'b0;
    else if (g_stg[STAGES-1].ld) ovf_q <= ovf_d;
  end
  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub: three instances (STAGES=4, 1, 8), table vectors,
// stall/reset sequences and random traffic against a queue scoreboard.
module tb_pipelined_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid_s [3];
  logic        in_ready_s [3];
  logic        sub_s      [3];
  logic        cin_s      [3];
  logic        out_valid_s[3];
  logic        out_ready_s[3];
  logic        co_s       [3];
  logic [31:0] a_s        [3];
  logic [31:0] b_s        [3];
  logic [31:0] f_s        [3];
`ifdef ADDER_OVF_EN
  logic        ov_s       [3];
`endif

  for (genvar d = 0; d < 3; d++) begin : g_dut
    pipelined_addsub #(.N(32), .STAGES((d == 0) ? 4 : (d == 1) ? 1 : 8)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid_s[d]),
      .in_ready (in_ready_s[d]),
      .a        (a_s[d]),
      .b        (b_s[d]),
      .sub      (sub_s[d]),
      .carryin  (cin_s[d]),
      .out_valid(out_valid_s[d]),
      .out_ready(out_ready_s[d]),
      .f        (f_s[d]),
      .carryout (co_s[d])
`ifdef ADDER_OVF_EN
      ,
      .ovf      (ov_s[d])
`endif
    );
  end

  typedef struct {
    logic [31:0] f;
    logic        co;
    logic        ov;
    int          adv;
  } exp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic        c;
    logic [31:0] f;
    logic        co;
    logic        ov;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   cur    = 0;
  exp_t q[$];

  function automatic int stg_of(input int d);
    return (d == 0) ? 4 : (d == 1) ? 1 : 8;
  endfunction

  function automatic void ref_model(input logic [31:0] av, input logic [31:0] bv,
                                    input logic s, input logic c,
                                    output logic [31:0] ef, output logic eco, output logic eov);
    longint sa, sb, r;
    logic [32:0] u;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    if (!s) begin
      u   = {1'b0, av} + {1'b0, bv} + {32'b0, c};
      ef  = u[31:0];
      eco = u[32];
      r   = sa + sb + longint'(c);
    end else begin
      ef  = av - bv - {31'b0, c};
      eco = ({1'b0, av} >= ({1'b0, bv} + {32'b0, c}));
      r   = sa - sb - longint'(c);
    end
    eov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t actual=%h required=%h", nm, cur, $time, act, req);
    end
  endtask

  // Called just after a rising edge; drives one cycle, checks at the falling edge, then
  // advances the scoreboard as the next rising edge will.
  task automatic step(input logic v, input logic [31:0] av, input logic [31:0] bv,
                      input logic s, input logic c, input logic rdy,
                      input logic [31:0] ef, input logic eco, input logic eov,
                      output logic acc);
    logic exp_ov, stall_m;
    exp_t e;
    in_valid_s[cur]  = v;
    a_s[cur]         = av;
    b_s[cur]         = bv;
    sub_s[cur]       = s;
    cin_s[cur]       = c;
    out_ready_s[cur] = rdy;
    @(negedge clk);
    exp_ov = (q.size() > 0) && (q[0].adv == stg_of(cur));
    chk("out_valid", 32'(out_valid_s[cur]), 32'(exp_ov));
    chk("in_ready", 32'(in_ready_s[cur]), 32'(!(exp_ov && !rdy)));
    if (exp_ov) begin
      chk("f", f_s[cur], q[0].f);
      chk("carryout", 32'(co_s[cur]), 32'(q[0].co));
`ifdef ADDER_OVF_EN
      chk("ovf", 32'(ov_s[cur]), 32'(q[0].ov));
`endif
    end
    stall_m = exp_ov && !rdy;
    acc     = v && !stall_m;
    if (!stall_m) begin
      if (exp_ov) void'(q.pop_front());
      for (int i = 0; i < q.size(); i++) begin
        e = q[i];
        e.adv++;
        q[i] = e;
      end
    end
    if (acc) begin
      e.f   = ef;
      e.co  = eco;
      e.ov  = eov;
      e.adv = 1;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, acc);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vt[12];
    logic        acc, v, s, c, rdy, eco, eov;
    logic [31:0] av, bv, ef;
    int          sent, cyc;

    vt[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vt[1]  = '{32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0};
    vt[2]  = '{32'h00000007, 32'h00000005, 1'b1, 1'b0, 32'h00000002, 1'b1, 1'b0};
    vt[3]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vt[4]  = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};
    vt[5]  = '{32'h00000003, 32'h00000004, 1'b0, 1'b0, 32'h00000007, 1'b0, 1'b0};
    vt[6]  = '{32'h0000FFFF, 32'h00000000, 1'b0, 1'b1, 32'h00010000, 1'b0, 1'b0};
    vt[7]  = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000006, 1'b1, 1'b0};
    vt[8]  = '{32'h00FF00FF, 32'hFF01FF01, 1'b0, 1'b0, 32'h00010000, 1'b1, 1'b0};
    vt[9]  = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
    vt[10] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vt[11] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};

    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid_s[d]  = 1'b0;
      a_s[d]         = '0;
      b_s[d]         = '0;
      sub_s[d]       = 1'b0;
      cin_s[d]       = 1'b0;
      out_ready_s[d] = 1'b1;
    end

    // Reset state, during and just after reset.
    #12;
    for (int d = 0; d < 3; d++) begin
      cur = d;
      chk("rst_out_valid", 32'(out_valid_s[d]), 32'h0);
      chk("rst_f", f_s[d], 32'h0);
      chk("rst_carryout", 32'(co_s[d]), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      cur = d;
      chk("post_rst_in_ready", 32'(in_ready_s[d]), 32'h1);
      chk("post_rst_out_valid", 32'(out_valid_s[d]), 32'h0);
      chk("post_rst_f", f_s[d], 32'h0);
    end

    // Table vectors, back to back at full rate, on the 4-stage instance.
    cur = 0;
    for (int i = 0; i < 12; i++)
      step(1'b1, vt[i].a, vt[i].b, vt[i].s, vt[i].c, 1'b1, vt[i].f, vt[i].co, vt[i].ov, acc);
    idle(6);
    chk("table_drained", 32'(q.size()), 32'h0);

    // Eight beats with a three-cycle downstream stall mid-stream.
    sent = 0;
    cyc  = 0;
    while ((sent < 8 || q.size() > 0) && cyc < 60) begin
      av  = 32'(sent);
      bv  = av << 28;
      rdy = !(cyc >= 5 && cyc < 8);
      ref_model(av, bv, 1'b0, 1'b0, ef, eco, eov);
      step(sent < 8, av, bv, 1'b0, 1'b0, rdy, ef, eco, eov, acc);
      if (acc) sent++;
      cyc++;
    end
    chk("stall_sent", 32'(sent), 32'd8);
    chk("stall_drained", 32'(q.size()), 32'h0);

    // Asynchronous reset mid-cycle with three beats in flight.
    for (int i = 1; i <= 3; i++) begin
      av = 32'(i * 1000);
      ref_model(av, 32'h11, 1'b0, 1'b0, ef, eco, eov);
      step(1'b1, av, 32'h11, 1'b0, 1'b0, 1'b1, ef, eco, eov, acc);
    end
    in_valid_s[cur] = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid_s[cur]), 32'h0);
    chk("midrst_f", f_s[cur], 32'h0);
    chk("midrst_carryout", 32'(co_s[cur]), 32'h0);
    q.delete();
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(6);
    chk("midrst_f_idle", f_s[cur], 32'h0);
    ref_model(32'h12345678, 32'h11111111, 1'b0, 1'b1, ef, eco, eov);
    step(1'b1, 32'h12345678, 32'h11111111, 1'b0, 1'b1, 1'b1, ef, eco, eov, acc);
    idle(6);
    chk("midrst_drained", 32'(q.size()), 32'h0);

    // Random traffic on the 1-stage and 8-stage instances.
    for (int d = 1; d < 3; d++) begin
      cur  = d;
      sent = 0;
      cyc  = 0;
      while (sent < 1000 && cyc < 6000) begin
        v   = ($urandom_range(0, 3) != 0);
        av  = $urandom;
        bv  = $urandom;
        s   = 1'($urandom_range(0, 1));
        c   = 1'($urandom_range(0, 1));
        rdy = ($urandom_range(0, 9) < 7);
        ref_model(av, bv, s, c, ef, eco, eov);
        step(v, av, bv, s, c, rdy, ef, eco, eov, acc);
        if (acc) sent++;
        cyc++;
      end
      chk("rand_sent", 32'(sent), 32'd1000);
      idle(stg_of(d) + 4);
      chk("rand_drained", 32'(q.size()), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
